// File: rtl/mau_sequencer.sv
// mau_sequencer: command FIFO plus whole-matrix staging buffer in front of
// the MAU host port, decoupling host valid/ready streams from MAU timing.
module mau_sequencer #(
   parameter int MATRIX_DIM = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [1:0] cmd_a,
   input  logic [1:0] cmd_d,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [7:0] wr_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic [7:0] rd_data,
   output logic [7:0] mau_instruction,
   output logic [7:0] mau_data_in,
   input  logic [7:0] mau_data_out,
   input  logic       mau_busy,
   output logic       seq_busy,
   output logic       cmd_done,
   output logic       cmd_err
);
   localparam int N  = MATRIX_DIM * MATRIX_DIM;
   localparam int IW = $clog2(N) + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [3:0] OP_LOAD  = 4'd1;
   localparam logic [3:0] OP_STORE = 4'd2;

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_ISSUE, S_LOAD_BURST,
      S_STORE_CAP, S_DRAIN, S_WAIT_BUSY, S_DONE
   } state_t;

   typedef struct packed {
      logic [3:0] op;
      logic [1:0] a;
      logic [1:0] d;
   } cmd_t;

   state_t  state_q, state_d;
   cmd_t    fifo_q [FIFO_DEPTH];
   cmd_t    cur_q, cur_d, head;
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          first_q, first_d;
   logic [7:0]    buf_q [N];
   logic          buf_we;
   logic [7:0]    buf_wdata;
   logic          push, pop;
   logic          is_load, is_other;

   logic       cmd_ready_q, cmd_ready_d;
   logic       wr_ready_q, wr_ready_d;
   logic       rd_valid_q, rd_valid_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic [7:0] instr_q, instr_d;
   logic [7:0] din_q, din_d;
   logic       seq_busy_q, seq_busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   assign head     = fifo_q[rp_q];
   assign is_load  = head.op == OP_LOAD;
   assign is_other = head.op >= OP_STORE && head.op <= 4'd7;

   always_comb begin
      push      = cmd_valid && cmd_ready_q;
      pop       = 1'b0;
      state_d   = state_q;
      cur_d     = cur_q;
      idx_d     = idx_q;
      first_d   = first_q;
      err_d     = 1'b0;
      buf_we    = 1'b0;
      buf_wdata = 8'h00;
      unique case (state_q)
         S_IDLE: begin
            if (cnt_q != '0) begin
               pop   = 1'b1;
               cur_d = head;
               idx_d = '0;
               unique case (1'b1)
                  is_load:  state_d = S_FILL;
                  is_other: state_d = S_ISSUE;
                  default:  err_d   = 1'b1;
               endcase
            end
         end
         S_FILL: begin
            if (wr_valid && wr_ready_q) begin
               buf_we    = 1'b1;
               buf_wdata = wr_data;
               idx_d     = idx_q + IW'(1);
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            idx_d   = '0;
            first_d = 1'b1;
            unique case (1'b1)
               cur_q.op == OP_LOAD:  state_d = S_LOAD_BURST;
               cur_q.op == OP_STORE: state_d = S_STORE_CAP;
               default:              state_d = S_WAIT_BUSY;
            endcase
         end
         S_LOAD_BURST: begin
            idx_d = idx_q + IW'(1);
            if (idx_q == LAST) begin
               idx_d   = '0;
               first_d = 1'b1;
               state_d = S_WAIT_BUSY;
            end
         end
         S_STORE_CAP: begin
            // first cycle covers the MAU read latency
            if (first_q) begin
               first_d = 1'b0;
            end else begin
               buf_we    = 1'b1;
               buf_wdata = mau_data_out;
               idx_d     = idx_q + IW'(1);
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (rd_valid_q && rd_ready) begin
               idx_d = idx_q + IW'(1);
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT_BUSY: begin
            if (first_q) first_d = 1'b0;
            else if (!mau_busy) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      wp_d  = push ? wp_q + PW'(1) : wp_q;
      rp_d  = pop ? rp_q + PW'(1) : rp_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);

      cmd_ready_d = cnt_d != FULL;
      wr_ready_d  = state_d == S_FILL;
      rd_valid_d  = state_d == S_DRAIN;
      rd_data_d   = (state_d == S_DRAIN) ? buf_q[idx_d[IW-2:0]] : 8'h00;
      instr_d     = (state_d == S_ISSUE) ? cur_d : 8'h00;
      din_d       = (state_d == S_LOAD_BURST) ? buf_q[idx_d[IW-2:0]] : 8'h00;
      seq_busy_d  = state_d != S_IDLE || cnt_d != '0;
      done_d      = state_d == S_DONE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         wp_q        <= '0;
         rp_q        <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         first_q     <= 1'b0;
         cmd_ready_q <= 1'b0;
         wr_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= 8'h00;
         instr_q     <= 8'h00;
         din_q       <= 8'h00;
         seq_busy_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         first_q     <= first_d;
         cmd_ready_q <= cmd_ready_d;
         wr_ready_q  <= wr_ready_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         instr_q     <= instr_d;
         din_q       <= din_d;
         seq_busy_q  <= seq_busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Storage arrays need no reset; pointers and idx define validity.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wp_q] <= {cmd_op, cmd_a, cmd_d};
      if (buf_we) buf_q[idx_q[IW-2:0]] <= buf_wdata;
   end

   assign cmd_ready       = cmd_ready_q;
   assign wr_ready        = wr_ready_q;
   assign rd_valid        = rd_valid_q;
   assign rd_data         = rd_data_q;
   assign mau_instruction = instr_q;
   assign mau_data_in     = din_q;
   assign seq_busy        = seq_busy_q;
   assign cmd_done        = done_q;
   assign cmd_err         = err_q;

endmodule

// File: doc/mau_sequencer.md
# mau_sequencer

Command scheduler in front of the MAU's 8-bit host port. Accepts macro-commands (LOAD, STORE, arithmetic, COPY) through a 4-deep command FIFO and stages whole matrices in an internal byte buffer. Issues one-cycle instruction bytes to the MAU and streams matrix data at the MAU's fixed one-byte-per-cycle rate, so host-side valid/ready streams never have to meet MAU timing.

## Interface
- matrix_dim, 8: matrix edge; N = matrix_dim*matrix_dim bytes per matrix
- fifo_depth, 4: command FIFO entries (power of two)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_op  in  4  opcode: 1 LOAD, 2 STORE, 3 ADD, 4 SHIFT, 5 SUB, 6 MUL, 7 COPY; others illegal
- cmd_a  in  2  BRAM index for aa / load-store target
- cmd_d  in  2  BRAM index for dd
- wr_valid / wr_ready / wr_data  in / out / in  1/1/8  host matrix-in stream
- rd_valid / rd_ready / rd_data  out / in / out  1/1/8  host matrix-out stream
- mau_instruction  out  8  {op[3:0], a[1:0], d[1:0]}; 0x00 = NOP
- mau_data_in  out  8  byte to MAU
- mau_data_out  in  8  byte from MAU
- mau_busy  in  1  MAU busy_flag
- seq_busy  out  1  FSM not in IDLE or FIFO non-empty
- cmd_done  out  1  one-cycle pulse per retired command
- cmd_err  out  1  one-cycle pulse per dropped illegal command

## Operation
- FIFO push on cmd_valid && cmd_ready; pop only in IDLE. cmd_ready = 0 when fifo_depth entries held.
- Staging buffer: N x 8 bits, index counter idx (clog2(N)+1 bits), wraps never — each phase runs idx 0..N-1 exactly.
- States: IDLE, FILL, ISSUE, LOAD_BURST, STORE_CAP, DRAIN, WAIT_BUSY, DONE.
- IDLE: if FIFO non-empty pop head. LOAD -> FILL; STORE, ADD..COPY -> ISSUE; op 0 or 8..15 -> pulse cmd_err, stay IDLE (no MAU traffic, no cmd_done).
- FILL: wr_ready = 1; each wr handshake writes buf[idx], idx++. After byte N-1 -> ISSUE.
- ISSUE (1 cycle): drive mau_instruction = {op,a,d}; next LOAD -> LOAD_BURST, STORE -> STORE_CAP, else -> WAIT_BUSY.
- LOAD_BURST: mau_data_in = buf[idx] for N consecutive cycles, no stalls; then -> WAIT_BUSY.
- STORE_CAP: skip first cycle (MAU read latency), then capture mau_data_out into buf[idx] for N consecutive cycles; then -> DRAIN.
- DRAIN: rd_valid = 1, rd_data = buf[idx]; idx++ on rd handshake; after byte N-1 -> DONE. rd_data held stable while rd_valid && !rd_ready.
- WAIT_BUSY: first cycle unconditional; thereafter leave to DONE on first cycle mau_busy = 0.
- DONE (1 cycle): cmd_done = 1; -> IDLE.
- mau_instruction = 0x00 and mau_data_in = 0x00 in every cycle not named above.
- Commands execute strictly in FIFO order; no overlap of two MAU operations.

## Timing
- Reset (rst = 0 at edge): FSM IDLE, FIFO empty, idx 0; all outputs 0 while rst low, including cmd_ready. cmd_ready = 1 first cycle after rst returns high.
- Reset mid-operation: abort immediately, discard FIFO and buffer contents, no cmd_done.
- Command accepted at edge E: earliest ISSUE at E+2 (one IDLE pop cycle) for non-LOAD.
- LOAD with wr_valid held high: FILL N cycles, ISSUE at cycle T, bytes k at T+1+k, WAIT_BUSY from T+1+N.
- STORE: ISSUE at T, mau_data_out byte k sampled at T+2+k; first rd_valid at T+2+N.
- Arithmetic: ISSUE at T, earliest cmd_done at T+3.
- Push while FIFO full: ignored (cmd_ready = 0). Push and pop same cycle when full: pop frees slot only next cycle.
- cmd_err and cmd_done never both high in one cycle.

## Test plan
- Reset: hold rst = 0 with cmd_valid = 1 -> all outputs 0, no push; release -> cmd_ready = 1 next cycle, seq_busy = 0.
- LOAD a=2: stream bytes 0..63 -> mau_instruction = 0x18 for one cycle, mau_data_in = 0..63 on the next 64 consecutive cycles, cmd_done once after mau_busy falls.
- STORE a=1 with MAU model returning 8'hA0+k: rd stream yields A0..DF in order under random rd_ready stalls, data stable during stalls, one cmd_done.
- Back-to-back ADD(a=0,d=1), MUL(a=2,d=3), COPY with 5th push while full -> cmd_ready low, instructions 0x31, 0x6B, 0x7x issued in order, each only after mau_busy dropped.
- Illegal op 9 queued between two ADDs -> cmd_err pulse, zero MAU traffic for it, both ADDs complete.
- rst low during LOAD_BURST byte 30 -> mau_data_in = 0 next cycle, FIFO empty, no cmd_done; fresh LOAD afterward succeeds.
